bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer.sv | 150 +++++++++++++++
 tb/tb_bit_serializer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// bit_serializer: double-buffered parallel-to-serial converter.
// One active shift register streams a word a bit per cycle. One holding
// register keeps the next word, so consecutive words come out with no gap
// bit between them. The output stream feeds a downstream sequence detector
// through data_out/bit_valid.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no active word; outputs quiet; a handshake starts a frame
//   ST_SHIFT | active word on data_out; holding slot may take next word
//
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             data_out,
    output logic             bit_valid,
    output logic             frame_done
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [WIDTH-1:0] hold_q;
    logic [WIDTH-1:0] hold_d;
    logic             hold_full_q;
    logic             hold_full_d;

    logic             handshake;
    logic             shifting;
    logic             last_bit;
    logic [WIDTH-1:0] shift_next;
    logic             out_bit;

    // Handshake qualifier; ready comes straight from the hold flag register,
    // so there is no combinational path from load_valid back to load_ready.
    always_comb begin
        load_ready = !hold_full_q;
        handshake  = load_valid && !hold_full_q;
        shifting   = (state_q == ST_SHIFT);
        last_bit   = shifting && (cnt_q == CNT_LAST);
    end

    // Shift direction: the bit on data_out always sits at the outgoing end
    // of the register, and the word moves toward it one place per cycle.
    always_comb begin
        shift_next = shift_q;
        out_bit    = 1'b0;
        if (MSB_FIRST) begin
            shift_next = {shift_q[WIDTH-2:0], 1'b0};
            out_bit    = shift_q[WIDTH-1];
        end else begin
            shift_next = {1'b0, shift_q[WIDTH-1:1]};
            out_bit    = shift_q[0];
        end
    end

    // Next-state logic for the frame sequencer and both word registers.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;

        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    shift_d = load_data;
                    cnt_d   = CNT_ZERO;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (!last_bit) begin
                    shift_d = shift_next;
                    cnt_d   = cnt_q + CNT_ONE;
                    if (handshake) begin
                        hold_d      = load_data;
                        hold_full_d = 1'b1;
                    end
                end else begin
                    // Frame boundary: refill from the holding slot first,
                    // otherwise take a word arriving this very cycle, so
                    // either way the next word follows with no gap bit.
                    cnt_d = CNT_ZERO;
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                    end else if (handshake) begin
                        shift_d = load_data;
                    end else begin
                        shift_d = '0;
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d     = ST_IDLE;
                cnt_d       = CNT_ZERO;
                shift_d     = '0;
                hold_full_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards both active and held words.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= CNT_ZERO;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    // Serial outputs are gated by the active state so IDLE stays quiet.
    always_comb begin
        bit_valid  = shifting;
        data_out   = shifting && out_bit;
        frame_done = last_bit;
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Testbench for bit_serializer: directed scenarios on three configurations
// plus a randomized run against a queue-based word/bit reference model.
module tb_bit_serializer;

    logic clk;
    logic rst;

    // A: WIDTH=4 MSB first, B: WIDTH=4 LSB first, C: WIDTH=8 MSB first
    logic       lv_a, lv_b, lv_c;
    logic [3:0] ld_a, ld_b;
    logic [7:0] ld_c;
    logic       rdy_a, do_a, bv_a, fd_a;
    logic       rdy_b, do_b, bv_b, fd_b;
    logic       rdy_c, do_c, bv_c, fd_c;

    int checks = 0;
    int errors = 0;

    // reference model for A: pending words in acceptance order, bits emitted of head
    int unsigned mq[$];
    int          mpos;

    bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .load_valid(lv_a), .load_data(ld_a),
        .load_ready(rdy_a), .data_out(do_a), .bit_valid(bv_a), .frame_done(fd_a));

    bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .load_valid(lv_b), .load_data(ld_b),
        .load_ready(rdy_b), .data_out(do_b), .bit_valid(bv_b), .frame_done(fd_b));

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_c (
        .clk(clk), .rst(rst), .load_valid(lv_c), .load_data(ld_c),
        .load_ready(rdy_c), .data_out(do_c), .bit_valid(bv_c), .frame_done(fd_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired got=timeout expected=finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({do_a, bv_a, fd_a, rdy_a} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_a got=%b expected=0001", {do_a, bv_a, fd_a, rdy_a});
        end
        checks++;
        if ({do_b, bv_b, fd_b, rdy_b} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_b got=%b expected=0001", {do_b, bv_b, fd_b, rdy_b});
        end
        checks++;
        if ({do_c, bv_c, fd_c, rdy_c} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_c got=%b expected=0001", {do_c, bv_c, fd_c, rdy_c});
        end
        rst = 1'b0;
        tick();
    endtask

    // single 4-bit word MSB first: 1,0,1,1 then idle
    task automatic test_single_word;
        logic [3:0] w;
        logic [3:0] exp;
        w    = 4'b1011;
        lv_a = 1'b1;
        ld_a = w;
        tick();
        lv_a = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            exp = {w[4-k], 1'b1, (k == 4), 1'b1};
            checks++;
            if ({do_a, bv_a, fd_a, rdy_a} !== exp) begin
                errors++;
                $display("FAIL single_bit%0d got=%b expected=%b", k, {do_a, bv_a, fd_a, rdy_a}, exp);
            end
            tick();
        end
        checks++;
        if ({do_a, bv_a, fd_a, rdy_a} !== 4'b0001) begin
            errors++;
            $display("FAIL single_idle got=%b expected=0001", {do_a, bv_a, fd_a, rdy_a});
        end
    endtask

    // two words with load_valid held: 8 contiguous bits, ready low while holding
    task automatic test_back_to_back;
        logic [7:0] stream;
        logic [3:0] exp;
        logic       exp_rdy;
        stream = 8'b1011_0110;
        lv_a   = 1'b1;
        ld_a   = 4'b1011;
        tick();
        for (int k = 1; k <= 8; k++) begin
            exp_rdy = !(k >= 2 && k <= 4);
            exp     = {stream[8-k], 1'b1, (k == 4 || k == 8), exp_rdy};
            checks++;
            if ({do_a, bv_a, fd_a, rdy_a} !== exp) begin
                errors++;
                $display("FAIL b2b_bit%0d got=%b expected=%b", k, {do_a, bv_a, fd_a, rdy_a}, exp);
            end
            if (k == 1) ld_a = 4'b0110;
            if (k == 2) lv_a = 1'b0;
            tick();
        end
        checks++;
        if ({do_a, bv_a, fd_a, rdy_a} !== 4'b0001) begin
            errors++;
            $display("FAIL b2b_idle got=%b expected=0001", {do_a, bv_a, fd_a, rdy_a});
        end
    endtask

    task automatic test_lsb_first;
        logic [3:0] bits;
        logic [3:0] exp;
        bits = 4'b1011;
        lv_b = 1'b1;
        ld_b = bits;
        tick();
        lv_b = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            exp = {bits[k-1], 1'b1, (k == 4), 1'b1};
            checks++;
            if ({do_b, bv_b, fd_b, rdy_b} !== exp) begin
                errors++;
                $display("FAIL lsb_bit%0d got=%b expected=%b", k, {do_b, bv_b, fd_b, rdy_b}, exp);
            end
            tick();
        end
        checks++;
        if ({do_b, bv_b, fd_b, rdy_b} !== 4'b0001) begin
            errors++;
            $display("FAIL lsb_idle got=%b expected=0001", {do_b, bv_b, fd_b, rdy_b});
        end
    endtask

    // reset during the third bit of 8'hA5, with a word offered at the reset edge
    task automatic test_reset_mid_frame;
        logic [7:0] w;
        logic [3:0] exp;
        w    = 8'hA5;
        lv_c = 1'b1;
        ld_c = w;
        tick();
        lv_c = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            exp = {w[8-k], 1'b1, 1'b0, 1'b1};
            checks++;
            if ({do_c, bv_c, fd_c, rdy_c} !== exp) begin
                errors++;
                $display("FAIL rstmid_bit%0d got=%b expected=%b", k, {do_c, bv_c, fd_c, rdy_c}, exp);
            end
            if (k == 3) begin
                rst  = 1'b1;
                lv_c = 1'b1;
                ld_c = 8'hFF;
            end
            tick();
        end
        rst  = 1'b0;
        lv_c = 1'b0;
        checks++;
        if ({do_c, bv_c, fd_c, rdy_c} !== 4'b0001) begin
            errors++;
            $display("FAIL rstmid_after got=%b expected=0001", {do_c, bv_c, fd_c, rdy_c});
        end
        tick();
        checks++;
        if ({do_c, bv_c, fd_c, rdy_c} !== 4'b0001) begin
            errors++;
            $display("FAIL rstmid_no_accept got=%b expected=0001", {do_c, bv_c, fd_c, rdy_c});
        end
        w    = 8'h3C;
        lv_c = 1'b1;
        ld_c = w;
        tick();
        lv_c = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            exp = {w[8-k], 1'b1, (k == 8), 1'b1};
            checks++;
            if ({do_c, bv_c, fd_c, rdy_c} !== exp) begin
                errors++;
                $display("FAIL rstmid_new_bit%0d got=%b expected=%b", k, {do_c, bv_c, fd_c, rdy_c}, exp);
            end
            tick();
        end
        checks++;
        if ({do_c, bv_c, fd_c, rdy_c} !== 4'b0001) begin
            errors++;
            $display("FAIL rstmid_new_idle got=%b expected=0001", {do_c, bv_c, fd_c, rdy_c});
        end
    endtask

    // load_data churns while the holding slot is full; held word must not change
    task automatic test_hold_stable;
        logic [7:0] stream;
        stream = 8'b0101_1100;
        lv_a   = 1'b1;
        ld_a   = 4'b0101;
        tick();
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if ({do_a, bv_a} !== {stream[8-k], 1'b1}) begin
                errors++;
                $display("FAIL hold_bit%0d got=%b expected=%b", k, {do_a, bv_a}, {stream[8-k], 1'b1});
            end
            if (k == 1) ld_a = 4'b1100;
            if (k >= 2 && k <= 4) ld_a = 4'($urandom);
            if (k == 5) lv_a = 1'b0;
            tick();
        end
        checks++;
        if (bv_a !== 1'b0) begin
            errors++;
            $display("FAIL hold_idle got=%b expected=0", bv_a);
        end
    endtask

    // feed the stream into a 1011 overlapping detector model
    task automatic test_detector;
        logic [3:0] win;
        logic [7:0] hit_mask;
        int         nbits;
        win      = '0;
        hit_mask = '0;
        nbits    = 0;
        lv_a     = 1'b1;
        ld_a     = 4'b1011;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (c == 0) ld_a = 4'b0110;
            if (c == 1) lv_a = 1'b0;
            if (bv_a === 1'b1) begin
                win = {win[2:0], do_a};
                nbits++;
                if (nbits >= 4 && nbits <= 8 && win == 4'b1011) hit_mask[nbits-1] = 1'b1;
            end
        end
        checks++;
        if (nbits !== 8) begin
            errors++;
            $display("FAIL detect_nbits got=%0d expected=8", nbits);
        end
        checks++;
        if (hit_mask !== 8'b0100_1000) begin
            errors++;
            $display("FAIL detect_hits got=%b expected=01001000", hit_mask);
        end
    endtask

    // random traffic on A against the word-queue model, with occasional reset
    task automatic test_random;
        logic       exp_bv, exp_do, exp_fd, exp_rdy;
        logic       r, v;
        logic [3:0] d;
        logic       acc;
        mq.delete();
        mpos = 0;
        rst  = 1'b1;
        lv_a = 1'b0;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 600; c++) begin
            exp_bv  = (mq.size() > 0);
            exp_do  = exp_bv ? mq[0][3 - mpos] : 1'b0;
            exp_fd  = exp_bv && (mpos == 3);
            exp_rdy = (mq.size() < 2);
            checks++;
            if ({do_a, bv_a, fd_a, rdy_a} !== {exp_do, exp_bv, exp_fd, exp_rdy}) begin
                errors++;
                $display("FAIL random_c%0d got=%b expected=%b", c, {do_a, bv_a, fd_a, rdy_a},
                         {exp_do, exp_bv, exp_fd, exp_rdy});
            end
            r    = (c < 560) && ($urandom_range(0, 59) == 0);
            v    = ($urandom_range(0, 9) < 6) && (c < 560);
            d    = 4'($urandom);
            rst  = r;
            lv_a = v;
            ld_a = d;
            if (r) begin
                mq.delete();
                mpos = 0;
            end else begin
                acc = v && (mq.size() < 2);
                if (mq.size() > 0) begin
                    mpos++;
                    if (mpos == 4) begin
                        void'(mq.pop_front());
                        mpos = 0;
                    end
                end
                if (acc) mq.push_back(32'(d));
            end
            tick();
        end
        rst  = 1'b0;
        lv_a = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        lv_a = 1'b0; ld_a = '0;
        lv_b = 1'b0; ld_b = '0;
        lv_c = 1'b0; ld_c = '0;
        @(negedge clk);
        test_reset();
        test_single_word();
        tick();
        test_back_to_back();
        tick();
        test_lsb_first();
        tick();
        test_reset_mid_frame();
        tick();
        test_hold_stable();
        tick();
        test_detector();
        tick();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
